leiwand_rv32_mem_arbiter: RTL and testbench

LEIWAND_RV32_MEM_ARBITER -- requirements
Module: leiwand_rv32_mem_arbiter

---
 rtl/leiwand_rv32_mem_arbiter_if.sv | 50 +++++
 rtl/leiwand_rv32_mem_arbiter.sv | 96 +++++++++
 tb/tb_leiwand_rv32_mem_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/leiwand_rv32_mem_arbiter_if.sv
// Bus bundle for the two-master / one-slave memory arbiter.
// The slave modport is the arbiter's view; the master modport is the environment driving it.
interface leiwand_rv32_mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic                m0_valid;
    logic [XLEN-1:0]     m0_addr;
    logic [XLEN-1:0]     m0_wdata;
    logic [XLEN/8-1:0]   m0_wen;
    logic                m0_ready;
    logic [XLEN-1:0]     m0_rdata;
    logic                m0_err;

    logic                m1_valid;
    logic [XLEN-1:0]     m1_addr;
    logic [XLEN-1:0]     m1_wdata;
    logic [XLEN/8-1:0]   m1_wen;
    logic                m1_ready;
    logic [XLEN-1:0]     m1_rdata;
    logic                m1_err;

    logic                s_valid;
    logic [XLEN-1:0]     s_addr;
    logic [XLEN-1:0]     s_wdata;
    logic [XLEN/8-1:0]   s_wen;
    logic                s_ready;
    logic [XLEN-1:0]     s_rdata;

    logic [1:0]          owner;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wen,
        output m0_ready, m0_rdata, m0_err,
        input  m1_valid, m1_addr, m1_wdata, m1_wen,
        output m1_ready, m1_rdata, m1_err,
        output s_valid, s_addr, s_wdata, s_wen,
        input  s_ready, s_rdata,
        output owner
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wen,
        input  m0_ready, m0_rdata, m0_err,
        output m1_valid, m1_addr, m1_wdata, m1_wen,
        input  m1_ready, m1_rdata, m1_err,
        input  s_valid, s_addr, s_wdata, s_wen,
        output s_ready, s_rdata,
        input  owner
    );
endinterface

// File: rtl/leiwand_rv32_mem_arbiter.sv
// Round-robin arbiter sharing one memory slave between two masters, with a per-grant
// wait timeout. Request routing and responses are combinational within the granted state.
module leiwand_rv32_mem_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    leiwand_rv32_mem_arbiter_if.slave bus
);
    // Encoding doubles as the owner output.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGnt0 = 2'b01,
        StGnt1 = 2'b10
    } state_e;

    localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

    state_e            r_state, w_state_d;
    logic [15:0]       r_wait, w_wait_d;
    logic              r_last_grant, w_last_grant_d;

    logic              w_gnt0, w_gnt1, w_granted;
    logic              w_valid, w_done, w_timeout, w_resp;
    logic [XLEN-1:0]   w_addr, w_wdata, w_rdata;
    logic [XLEN/8-1:0] w_wen;

    always_comb begin
        w_gnt0    = (r_state == StGnt0);
        w_gnt1    = (r_state == StGnt1);
        w_granted = w_gnt0 | w_gnt1;
        w_valid   = w_gnt1 ? bus.m1_valid : bus.m0_valid;
        w_addr    = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
        w_wdata   = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
        w_wen     = w_gnt1 ? bus.m1_wen   : bus.m0_wen;
        // s_ready beats the timeout when both land in the same cycle.
        w_done    = w_granted & bus.s_ready;
        w_timeout = w_granted & ~bus.s_ready & w_valid & (r_wait == WaitLast);
        w_resp    = w_done | w_timeout;
        w_rdata   = w_done ? bus.s_rdata : {XLEN{1'b1}};
    end

    always_comb begin
        bus.s_valid  = w_granted & w_valid;
        bus.s_addr   = w_granted ? w_addr  : '0;
        bus.s_wdata  = w_granted ? w_wdata : '0;
        bus.s_wen    = w_granted ? w_wen   : '0;
        bus.m0_ready = w_gnt0 & w_resp;
        bus.m0_err   = w_gnt0 & w_timeout;
        bus.m0_rdata = (w_gnt0 && w_resp) ? w_rdata : '0;
        bus.m1_ready = w_gnt1 & w_resp;
        bus.m1_err   = w_gnt1 & w_timeout;
        bus.m1_rdata = (w_gnt1 && w_resp) ? w_rdata : '0;
        bus.owner    = r_state;
    end

    always_comb begin
        w_state_d      = r_state;
        w_wait_d       = r_wait;
        w_last_grant_d = r_last_grant;
        unique case (r_state)
            StIdle: begin
                w_wait_d = '0;
                if (bus.m0_valid && (!bus.m1_valid || r_last_grant)) begin
                    w_state_d = StGnt0;
                end else if (bus.m1_valid) begin
                    w_state_d = StGnt1;
                end
            end
            StGnt0, StGnt1: begin
                if (w_resp) begin
                    w_state_d      = StIdle;
                    w_last_grant_d = w_gnt1;
                end else if (!w_valid) begin
                    w_state_d = StIdle;
                end else begin
                    w_wait_d = r_wait + 16'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_wait       <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_d;
            r_wait       <= w_wait_d;
            r_last_grant <= w_last_grant_d;
        end
    end
endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
// Directed, table-driven bench for the memory arbiter (TIMEOUT=4), plus hand-written
// reset sequences around the table.
module tb_leiwand_rv32_mem_arbiter;
    typedef struct packed {
        logic        m0_v;
        logic [31:0] m0_a;
        logic [3:0]  m0_w;
        logic [31:0] m0_d;
        logic        m1_v;
        logic [31:0] m1_a;
        logic [3:0]  m1_w;
        logic [31:0] m1_d;
        logic        s_r;
        logic [31:0] s_rd;
    } in_t;

    typedef struct packed {
        logic [1:0]  owner;
        logic        s_v;
        logic [31:0] s_a;
        logic [3:0]  s_w;
        logic [31:0] s_d;
        logic        m0_r;
        logic        m0_e;
        logic [31:0] m0_rd;
        logic        m1_r;
        logic        m1_e;
        logic [31:0] m1_rd;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [31:0] A0 = 32'h8000_0010;
    localparam logic [31:0] A1 = 32'h8000_0020;
    localparam logic [31:0] A2 = 32'h8000_0100;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] WD = 32'h1234_5678;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    out_t idl;

    always #5 clk = ~clk;

    leiwand_rv32_mem_arbiter_if #(.XLEN(32)) bus ();

    leiwand_rv32_mem_arbiter #(
        .XLEN    (32),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic in_t mi(logic m0v, logic [31:0] m0a, logic [3:0] m0w, logic [31:0] m0d,
                               logic m1v, logic [31:0] m1a, logic [3:0] m1w, logic [31:0] m1d,
                               logic sr, logic [31:0] srd);
        return {m0v, m0a, m0w, m0d, m1v, m1a, m1w, m1d, sr, srd};
    endfunction

    // Response fields land on whichever master the owner code names.
    function automatic out_t og(logic [1:0] own, logic sv, logic [31:0] a, logic [3:0] w,
                                logic [31:0] d, logic r, logic e, logic [31:0] rd);
        out_t o;
        o       = '0;
        o.owner = own;
        o.s_v   = sv;
        o.s_a   = a;
        o.s_w   = w;
        o.s_d   = d;
        if (own == 2'b01) begin
            o.m0_r  = r;
            o.m0_e  = e;
            o.m0_rd = rd;
        end else if (own == 2'b10) begin
            o.m1_r  = r;
            o.m1_e  = e;
            o.m1_rd = rd;
        end
        return o;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t v);
        bus.m0_valid = v.m0_v;
        bus.m0_addr  = v.m0_a;
        bus.m0_wen   = v.m0_w;
        bus.m0_wdata = v.m0_d;
        bus.m1_valid = v.m1_v;
        bus.m1_addr  = v.m1_a;
        bus.m1_wen   = v.m1_w;
        bus.m1_wdata = v.m1_d;
        bus.s_ready  = v.s_r;
        bus.s_rdata  = v.s_rd;
    endtask

    task automatic check(input string nm, input out_t exp);
        out_t act;
        act = {bus.owner, bus.s_valid, bus.s_addr, bus.s_wen, bus.s_wdata,
               bus.m0_ready, bus.m0_err, bus.m0_rdata,
               bus.m1_ready, bus.m1_err, bus.m1_rdata};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (owner %b vs %b)",
                     nm, act, exp, act.owner, exp.owner);
        end
    endtask

    initial begin
        idl = og(2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);

        // Tie after reset, then alternation.
        add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), idl);
        add(mi(1, A0, 0, 0, 1, A1, 0, 0, 0, 0), idl);
        add(mi(1, A0, 0, 0, 1, A1, 0, 0, 1, DB), og(1, 1, A0, 0, 0, 1, 0, DB));
        add(mi(0, 0, 0, 0, 1, A1, 0, 0, 0, 0), idl);
        add(mi(0, 0, 0, 0, 1, A1, 0, 0, 1, 32'h1111_2222), og(2, 1, A1, 0, 0, 1, 0, 32'h1111_2222));
        add(mi(1, A0, 0, 0, 1, A1, 0, 0, 0, 0), idl);
        add(mi(1, A0, 0, 0, 1, A1, 0, 0, 1, 32'h3333_4444), og(1, 1, A0, 0, 0, 1, 0, 32'h3333_4444));
        // Single read, slave answers on the third grant cycle; then stray s_ready in idle.
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), idl);
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), og(1, 1, A0, 0, 0, 0, 0, 0));
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), og(1, 1, A0, 0, 0, 0, 0, 0));
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 1, DB), og(1, 1, A0, 0, 0, 1, 0, DB));
        add(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D), idl);
        // Write routing from master 1.
        add(mi(0, 0, 0, 0, 1, A2, 4'hF, WD, 0, 0), idl);
        add(mi(0, 0, 0, 0, 1, A2, 4'hF, WD, 0, 0), og(2, 1, A2, 4'hF, WD, 0, 0, 0));
        add(mi(0, 0, 0, 0, 1, A2, 4'hF, WD, 1, 32'hAAAA_5555),
            og(2, 1, A2, 4'hF, WD, 1, 0, 32'hAAAA_5555));
        // Timeout on the fourth grant cycle.
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), idl);
        for (int k = 0; k < 3; k++) begin
            add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), og(1, 1, A0, 0, 0, 0, 0, 0));
        end
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), og(1, 1, A0, 0, 0, 1, 1, 32'hFFFF_FFFF));
        // s_ready on the fourth cycle wins over the timeout.
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), idl);
        for (int k = 0; k < 3; k++) begin
            add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), og(1, 1, A0, 0, 0, 0, 0, 0));
        end
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A_5A5A), og(1, 1, A0, 0, 0, 1, 0, 32'h5A5A_5A5A));
        // Abort by master 0 with master 1 pending.
        add(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0), idl);
        add(mi(1, A0, 0, 0, 1, A1, 0, 0, 0, 0), og(1, 1, A0, 0, 0, 0, 0, 0));
        add(mi(0, A0, 0, 0, 1, A1, 0, 0, 0, 0), og(1, 0, A0, 0, 0, 0, 0, 0));
        add(mi(0, 0, 0, 0, 1, A1, 0, 0, 0, 0), idl);
        add(mi(0, 0, 0, 0, 1, A1, 0, 0, 1, 32'h0000_0077), og(2, 1, A1, 0, 0, 1, 0, 32'h0000_0077));
        add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), idl);

        // Reset held with a live request: outputs stay zero; first edge after release grants.
        reset = 1'b1;
        drive(mi(1, A0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", idl);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_arb", og(1, 1, A0, 0, 0, 0, 0, 0));
        #1 reset = 1'b1;
        #1 check("reset_async_gnt0", idl);
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            @(posedge clk);
            #1 drive(vecs[n].i);
            @(negedge clk);
            check($sformatf("vec[%0d]", n), vecs[n].o);
        end

        // Reset pulsed between edges during GNT1, then re-arbitration.
        @(posedge clk);
        #1 drive(mi(0, 0, 0, 0, 1, A1, 0, 0, 0, 0));
        @(negedge clk);
        check("r1_idle", idl);
        @(posedge clk);
        @(negedge clk);
        check("r1_gnt", og(2, 1, A1, 0, 0, 0, 0, 0));
        #1 reset = 1'b1;
        #1 check("r1_async", idl);
        drive(mi(0, 0, 0, 0, 1, A1, 0, 0, 1, 32'h0000_0099));
        #1 reset = 1'b0;
        #1 check("r1_released", idl);
        @(posedge clk);
        @(negedge clk);
        check("r1_rearb", og(2, 1, A1, 0, 0, 1, 0, 32'h0000_0099));
        @(posedge clk);
        #1 drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("r1_done", idl);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
